// File: rtl/egr_tag_rx_pkg.sv
// Shared types, widths and small arithmetic helpers for the egress tag
// receive stage.
package egr_tag_rx_pkg;

    localparam int PORT_W = 6;
    localparam int CRED_W = 2;
    localparam int DROP_W = 16;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [2:0]        tc;
        logic [19:0]       ptr;
        logic [13:0]       len;
    } tag_t;

    localparam int TAG_W    = $bits(tag_t);
    // Bit position of tag_t.port inside a flat tag vector.
    localparam int PORT_LSB = TAG_W - PORT_W;
    // FIFO entry layout: {is_mc, tag}.
    localparam int ENTRY_W  = TAG_W + 1;

    // Credits handed back to one ring in one cycle: a filter drop plus a pop.
    function automatic logic [CRED_W-1:0] credit_sum(input logic drop, input logic pop);
        return {1'b0, drop} + {1'b0, pop};
    endfunction

    // Drop counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                       input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
        if (sum[DROP_W]) begin
            return {DROP_W{1'b1}};
        end else begin
            return sum[DROP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/egr_tag_rx_fifo.sv
// Two-write / one-read circular FIFO. The second write port lands in the
// slot after the first, so a caller asserting wr1_en must also assert wr0_en.
// Each entry carries the tag plus its source bit in the MSB.
module egr_tag_rx_fifo
    import egr_tag_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr0_en,
    input  logic [ENTRY_W-1:0]        wr0_data,
    input  logic                      wr1_en,
    input  logic [ENTRY_W-1:0]        wr1_data,
    input  logic                      rd_en,
    output logic [ENTRY_W-1:0]        head_data,
    output logic                      not_empty,
    output logic [$clog2(DEPTH):0]    free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;

    logic [AW-1:0]      wr_ptr_p1_s;
    logic [1:0]         n_wr_s;
    logic               rd_fire_s;
    logic [CW-1:0]      count_next_s;

    // Second write slot, write count and next occupancy (reads never underflow).
    always_comb begin
        wr_ptr_p1_s  = wr_ptr_r + AW'(1'b1);
        n_wr_s       = {1'b0, wr0_en} + {1'b0, wr1_en};
        rd_fire_s    = rd_en & (count_r != {CW{1'b0}});
        count_next_s = count_r + CW'(n_wr_s) - CW'(rd_fire_s);
    end

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (wr0_en) begin
                mem_r[wr_ptr_r] <= wr0_data;
            end
            if (wr1_en) begin
                mem_r[wr_ptr_p1_s] <= wr1_data;
            end
        end
    end

    // Pointers wrap naturally; occupancy tracks writes minus pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(n_wr_s);
            rd_ptr_r <= rd_ptr_r + AW'(rd_fire_s);
            count_r  <= count_next_s;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign not_empty = (count_r != {CW{1'b0}});
    // Free slots are counted before this cycle's pop: a pop never makes room
    // for a write in the same cycle.
    assign free_cnt  = CW'(DEPTH) - count_r;

endmodule

// File: rtl/egr_tag_rx.sv
// Egress tag receive stage: filters unicast and multicast tags by egress
// port, merges kept tags (UC before MC) into a shared FIFO toward the TMU
// and returns one credit per dropped or popped tag to its source ring.
module egr_tag_rx
    import egr_tag_rx_pkg::*;
#(
    parameter logic [PORT_W-1:0] PORT_ID    = 6'd0,
    parameter int                DEPTH      = 16,
    parameter int                UC_CREDITS = 8,
    parameter int                MC_CREDITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uc_valid,
    input  logic [TAG_W-1:0]  uc_tag,
    input  logic              mc_valid,
    input  logic [TAG_W-1:0]  mc_tag,
    output logic [CRED_W-1:0] uc_credit_ret,
    output logic [CRED_W-1:0] mc_credit_ret,
    output logic              tmu_valid,
    input  logic              tmu_ready,
    output logic [TAG_W-1:0]  tmu_tag,
    output logic              tmu_is_mc,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Elaboration-time sanity check on the credit pool and FIFO geometry.
    if (((UC_CREDITS + MC_CREDITS) != DEPTH) || (DEPTH < 32'sd4) ||
        ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_param_check
        $error("egr_tag_rx: DEPTH must be a power of 2 >= 4 and equal UC_CREDITS + MC_CREDITS");
    end

    logic               uc_keep_s;
    logic               uc_drop_s;
    logic               mc_keep_s;
    logic               mc_drop_s;
    logic               wr0_en_s;
    logic               wr1_en_s;
    logic [ENTRY_W-1:0] wr0_data_s;
    logic [ENTRY_W-1:0] wr1_data_s;
    logic               ovf_s;
    logic [CW-1:0]      free_s;
    logic [ENTRY_W-1:0] head_s;
    logic               not_empty_s;
    logic               head_is_mc_s;
    logic               pop_s;

    logic [CRED_W-1:0]  uc_credit_ret_r;
    logic [CRED_W-1:0]  mc_credit_ret_r;
    logic [DROP_W-1:0]  drop_cnt_r;
    logic               ovf_err_r;

    // Port filter: a tag is kept only when addressed to this egress port.
    always_comb begin
        uc_keep_s = uc_valid &  (uc_tag[TAG_W-1:PORT_LSB] == PORT_ID);
        uc_drop_s = uc_valid & ~(uc_tag[TAG_W-1:PORT_LSB] == PORT_ID);
        mc_keep_s = mc_valid &  (mc_tag[TAG_W-1:PORT_LSB] == PORT_ID);
        mc_drop_s = mc_valid & ~(mc_tag[TAG_W-1:PORT_LSB] == PORT_ID);
    end

    // Write steering: UC takes the first slot; any kept tag without a slot overflows.
    always_comb begin
        wr0_en_s   = 1'b0;
        wr1_en_s   = 1'b0;
        wr0_data_s = {1'b0, uc_tag};
        wr1_data_s = {1'b1, mc_tag};
        ovf_s      = 1'b0;
        if (uc_keep_s && mc_keep_s) begin
            if (free_s >= CW'(2'd2)) begin
                wr0_en_s = 1'b1;
                wr1_en_s = 1'b1;
            end else if (free_s == CW'(1'b1)) begin
                wr0_en_s = 1'b1;
                ovf_s    = 1'b1;
            end else begin
                ovf_s    = 1'b1;
            end
        end else if (uc_keep_s) begin
            if (free_s != {CW{1'b0}}) begin
                wr0_en_s = 1'b1;
            end else begin
                ovf_s    = 1'b1;
            end
        end else if (mc_keep_s) begin
            wr0_data_s = {1'b1, mc_tag};
            if (free_s != {CW{1'b0}}) begin
                wr0_en_s = 1'b1;
            end else begin
                ovf_s    = 1'b1;
            end
        end else begin
            wr0_en_s = 1'b0;
        end
    end

    egr_tag_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (wr0_en_s),
        .wr0_data  (wr0_data_s),
        .wr1_en    (wr1_en_s),
        .wr1_data  (wr1_data_s),
        .rd_en     (pop_s),
        .head_data (head_s),
        .not_empty (not_empty_s),
        .free_cnt  (free_s)
    );

    assign head_is_mc_s = head_s[ENTRY_W-1];
    assign pop_s        = not_empty_s & tmu_ready;

    // Credit return, drop statistics and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uc_credit_ret_r <= {CRED_W{1'b0}};
            mc_credit_ret_r <= {CRED_W{1'b0}};
            drop_cnt_r      <= {DROP_W{1'b0}};
            ovf_err_r       <= 1'b0;
        end else begin
            uc_credit_ret_r <= credit_sum(uc_drop_s, pop_s & ~head_is_mc_s);
            mc_credit_ret_r <= credit_sum(mc_drop_s, pop_s &  head_is_mc_s);
            drop_cnt_r      <= sat_add_drop(drop_cnt_r, {1'b0, uc_drop_s} + {1'b0, mc_drop_s});
            ovf_err_r       <= ovf_err_r | ovf_s;
        end
    end

    assign uc_credit_ret = uc_credit_ret_r;
    assign mc_credit_ret = mc_credit_ret_r;
    assign drop_cnt      = drop_cnt_r;
    assign ovf_err       = ovf_err_r;
    assign tmu_valid     = not_empty_s;
    assign tmu_tag       = head_s[TAG_W-1:0];
    assign tmu_is_mc     = head_is_mc_s;

endmodule

// File: tb/tb_egr_tag_rx.sv
// Scoreboard bench for egr_tag_rx: the driver applies the filter / ordering /
// full rules to decide what should be queued, and an independent monitor
// compares everything the DUT presents against that expectation.
module tb_egr_tag_rx;
    import egr_tag_rx_pkg::*;

    localparam logic [5:0] PID   = 6'd5;
    localparam int         DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              uc_valid, mc_valid, tmu_ready;
    logic [TAG_W-1:0]  uc_tag, mc_tag;
    logic [CRED_W-1:0] uc_credit_ret, mc_credit_ret;
    logic              tmu_valid, tmu_is_mc, ovf_err;
    logic [TAG_W-1:0]  tmu_tag;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    egr_tag_rx #(
        .PORT_ID(PID), .DEPTH(DEPTH), .UC_CREDITS(8), .MC_CREDITS(8)
    ) dut (
        .clk(clk), .rst(rst),
        .uc_valid(uc_valid), .uc_tag(uc_tag),
        .mc_valid(mc_valid), .mc_tag(mc_tag),
        .uc_credit_ret(uc_credit_ret), .mc_credit_ret(mc_credit_ret),
        .tmu_valid(tmu_valid), .tmu_ready(tmu_ready),
        .tmu_tag(tmu_tag), .tmu_is_mc(tmu_is_mc),
        .drop_cnt(drop_cnt), .ovf_err(ovf_err)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             is_mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cur_push = 0;
    bit   cur_uc_drop = 1'b0, cur_mc_drop = 1'b0, cur_ovf = 1'b0;
    int   exp_uc_ret = 0, exp_mc_ret = 0, drop_model = 0;
    bit   ovf_model = 1'b0;
    bit   mon_en = 1'b0;
    exp_t mon_e;
    bit   pop_uc_m, pop_mc_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [TAG_W-1:0] mk_tag(input logic [5:0] p);
        return {p, 3'($urandom), 20'($urandom), 14'($urandom)};
    endfunction

    function automatic logic [5:0] other_port();
        logic [5:0] p;
        do p = 6'($urandom); while (p == PID);
        return p;
    endfunction

    // Apply the receive rules for one arriving tag to the expected queue.
    task automatic accept(input bit v, input logic [TAG_W-1:0] t, input bit is_mc, inout int free);
        logic [5:0] p;
        if (!v) return;
        p = t[TAG_W-1 -: 6];
        if (p != PID) begin
            if (is_mc) cur_mc_drop = 1'b1;
            else       cur_uc_drop = 1'b1;
        end else if (free > 0) begin
            exp_q.push_back('{tag: t, is_mc: is_mc});
            free--;
            cur_push++;
        end else begin
            cur_ovf = 1'b1;
        end
    endtask

    task automatic drive(input bit uv, input logic [TAG_W-1:0] ut,
                         input bit mv, input logic [TAG_W-1:0] mt, input bit rdy);
        int free;
        @(posedge clk);
        #1;
        uc_valid = uv; uc_tag = ut; mc_valid = mv; mc_tag = mt; tmu_ready = rdy;
        free = DEPTH - exp_q.size();
        cur_push = 0; cur_uc_drop = 1'b0; cur_mc_drop = 1'b0; cur_ovf = 1'b0;
        accept(uv, ut, 1'b0, free);
        accept(mv, mt, 1'b1, free);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, mk_tag(PID), 1'b0, mk_tag(PID), rdy);
    endtask

    // Monitor: checks head order on every handshake plus credits, stats and flags.
    always @(negedge clk) begin
        if (mon_en) begin
            pop_uc_m = 1'b0;
            pop_mc_m = 1'b0;
            chk("tmu_valid", 64'(tmu_valid), 64'((exp_q.size() - cur_push) > 0));
            if (tmu_valid && tmu_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_empty: got a handshake, expected an empty queue at t=%0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tmu_tag", 64'(tmu_tag), 64'(mon_e.tag));
                    chk("tmu_is_mc", 64'(tmu_is_mc), 64'(mon_e.is_mc));
                    pop_uc_m = !mon_e.is_mc;
                    pop_mc_m = mon_e.is_mc;
                end
            end
            chk("uc_credit_ret", 64'(uc_credit_ret), 64'(exp_uc_ret));
            chk("mc_credit_ret", 64'(mc_credit_ret), 64'(exp_mc_ret));
            chk("drop_cnt", 64'(drop_cnt), 64'(drop_model));
            chk("ovf_err", 64'(ovf_err), 64'(ovf_model));
            exp_uc_ret = int'(cur_uc_drop) + int'(pop_uc_m);
            exp_mc_ret = int'(cur_mc_drop) + int'(pop_mc_m);
            drop_model = drop_model + int'(cur_uc_drop) + int'(cur_mc_drop);
            if (drop_model > 65535) drop_model = 65535;
            ovf_model = ovf_model | cur_ovf;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tmu_valid"}, 64'(tmu_valid), 64'd0);
        chk({tag, "_tmu_tag"}, 64'(tmu_tag), 64'd0);
        chk({tag, "_tmu_is_mc"}, 64'(tmu_is_mc), 64'd0);
        chk({tag, "_uc_credit_ret"}, 64'(uc_credit_ret), 64'd0);
        chk({tag, "_mc_credit_ret"}, 64'(mc_credit_ret), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_ovf_err"}, 64'(ovf_err), 64'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        cur_push = 0; cur_uc_drop = 1'b0; cur_mc_drop = 1'b0; cur_ovf = 1'b0;
        exp_uc_ret = 0; exp_mc_ret = 0; drop_model = 0; ovf_model = 1'b0;
    endtask

    initial begin
        int pct;
        rst = 1'b1;
        uc_valid = 1'b0; mc_valid = 1'b0; tmu_ready = 1'b0;
        uc_tag = '0; mc_tag = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("init");
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        // single kept UC tag, TMU ready
        drive(1'b1, mk_tag(PID), 1'b0, mk_tag(PID), 1'b1);
        idle(1'b1, 3);
        // dual kept tags while TMU stalls, then drain: UC first, MC second
        drive(1'b1, mk_tag(PID), 1'b1, mk_tag(PID), 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);
        // UC-only drop, then a drop on both rings
        drive(1'b1, mk_tag(other_port()), 1'b0, mk_tag(PID), 1'b1);
        drive(1'b1, mk_tag(other_port()), 1'b1, mk_tag(other_port()), 1'b1);
        idle(1'b1, 2);
        // fill all 16 slots, then one UC tag overflows
        repeat (8) drive(1'b1, mk_tag(PID), 1'b1, mk_tag(PID), 1'b0);
        drive(1'b1, mk_tag(PID), 1'b0, mk_tag(PID), 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 18);
        // 15 filled, then a dual arrival: UC fits, MC overflows
        repeat (7) drive(1'b1, mk_tag(PID), 1'b1, mk_tag(PID), 1'b0);
        drive(1'b1, mk_tag(PID), 1'b0, mk_tag(PID), 1'b0);
        drive(1'b1, mk_tag(PID), 1'b1, mk_tag(PID), 1'b0);
        idle(1'b1, 18);
        // pop of a UC entry together with a UC drop, then the MC equivalent
        drive(1'b1, mk_tag(PID), 1'b0, mk_tag(PID), 1'b0);
        drive(1'b1, mk_tag(other_port()), 1'b0, mk_tag(PID), 1'b1);
        drive(1'b0, mk_tag(PID), 1'b1, mk_tag(PID), 1'b0);
        drive(1'b0, mk_tag(PID), 1'b1, mk_tag(other_port()), 1'b1);
        idle(1'b1, 3);

        // randomized traffic with varying TMU back-pressure
        for (int c = 0; c < 6; c++) begin
            pct = (c % 3 == 0) ? 90 : ((c % 3 == 1) ? 20 : 60);
            for (int i = 0; i < 500; i++) begin
                drive(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0) ? mk_tag(PID) : mk_tag(other_port()),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0) ? mk_tag(PID) : mk_tag(other_port()),
                      1'($urandom_range(0, 99) < pct));
            end
        end
        idle(1'b1, 20);

        // reset with 5 entries queued
        repeat (5) drive(1'b1, mk_tag(PID), 1'b0, mk_tag(PID), 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        uc_valid = 1'b0; mc_valid = 1'b0; tmu_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        clear_model();
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;
        idle(1'b1, 4);
        drive(1'b0, mk_tag(PID), 1'b1, mk_tag(PID), 1'b1);
        idle(1'b1, 3);

        // drop counter saturation
        repeat (32800) drive(1'b1, mk_tag(other_port()), 1'b1, mk_tag(other_port()), 1'b1);
        idle(1'b1, 3);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
